// File: rtl/service_arbiter.sv
// Round-robin arbiter granting one board service at a time and routing the shared button/display to it.
// Optional grant watchdog with wd_trip output: define SVC_WATCHDOG_EN.
module service_arbiter #(
  parameter int          N_SVC          = 4,
  parameter int          ID_W           = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000_000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_SVC-1:0]     spdt,
  input  logic                 push_m,
  input  logic [N_SVC-1:0]     finish,
  input  logic [16*N_SVC-1:0]  seg_in,
  input  logic [N_SVC-1:0]     led_in,
  output logic [N_SVC-1:0]     svc_en,
  output logic [N_SVC-1:0]     push_out,
  output logic [15:0]          segments,
  output logic                 led,
  output logic [ID_W-1:0]      active_id,
  output logic                 busy
`ifdef SVC_WATCHDOG_EN
  ,
  output logic                 wd_trip
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

  state_t            r_state, w_state_nxt;
  logic [N_SVC-1:0]  r_svc_en;
  logic [ID_W-1:0]   r_active_id;
  logic [ID_W-1:0]   r_last_id;
  logic              r_busy;
  logic              r_push_prev;

  logic              w_pick_valid;
  logic [ID_W-1:0]   w_pick_id;
  logic [ID_W-1:0]   w_cand;
  logic              w_user_exit;
  logic              w_wd_hit;
  logic              w_exit_cond;
  logic              w_grant;
  logic              w_release;
  logic [15:0]       w_seg_sel;
  logic              w_led_sel;

  // Walk from the farthest candidate to the nearest so the nearest set bit after last_id wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_pick_valid = 1'b0;
    w_pick_id    = '0;
    w_cand       = '0;
    for (int k = N_SVC; k >= 1; k--) begin
      w_cand = ID_W'((int'(r_last_id) + k) % N_SVC);
      if (spdt[w_cand]) begin
        w_pick_valid = 1'b1;
        w_pick_id    = w_cand;
      end
    end
  end

  always_comb begin
    w_seg_sel = 16'h0000;
    w_led_sel = 1'b0;
    for (int i = 0; i < N_SVC; i++) begin
      if (r_active_id == ID_W'(i)) begin
        w_seg_sel = seg_in[16*i +: 16];
        w_led_sel = led_in[i];
      end
    end
  end

  assign w_user_exit = finish[r_active_id] | ~spdt[r_active_id];
  assign w_exit_cond = w_user_exit | w_wd_hit;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (resetn) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: if (w_pick_valid) begin
        w_state_nxt = S_GRANT;
        w_grant     = 1'b1;
      end
      S_GRANT: if (w_exit_cond) begin
        w_state_nxt = S_RELEASE;
        w_release   = 1'b1;
      end
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_svc_en    <= '0;
      r_busy      <= 1'b0;
      r_active_id <= '0;
      r_last_id   <= ID_W'(N_SVC-1);
      r_push_prev <= 1'b0;
    end else begin
      r_push_prev <= push_m;
      if (w_grant) begin
        r_active_id <= w_pick_id;
        r_svc_en    <= N_SVC'(1) << w_pick_id;
        r_busy      <= 1'b1;
      end else if (w_release) begin
        r_svc_en    <= '0;
        r_busy      <= 1'b0;
        r_last_id   <= r_active_id;
      end
    end
  end

`ifdef SVC_WATCHDOG_EN
  logic [31:0] r_wd_cnt;
  logic        r_wd_trip;

  assign w_wd_hit = (r_state == S_GRANT) && (r_wd_cnt == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_wd_cnt  <= '0;
      r_wd_trip <= 1'b0;
    end else begin
      // Trip only flags a forced release, not one that coincides with a normal exit.
      r_wd_trip <= w_wd_hit && !w_user_exit;
      if (w_grant)                 r_wd_cnt <= '0;
      else if (r_state == S_GRANT) r_wd_cnt <= r_wd_cnt + 32'd1;
    end
  end

  assign wd_trip = r_wd_trip;
`else
  assign w_wd_hit = 1'b0;
`endif

  // Display, LED and button pulse reach the service only while it holds the grant.
  always_comb begin
    segments = 16'h0000;
    led      = 1'b0;
    push_out = '0;
    if (r_state == S_GRANT) begin
      segments = w_seg_sel;
      led      = w_led_sel;
      if (push_m && !r_push_prev && !w_exit_cond) push_out = r_svc_en;
    end
  end

  assign svc_en    = r_svc_en;
  assign busy      = r_busy;
  assign active_id = r_active_id;

endmodule

// File: doc/service_arbiter.md
Name: service_arbiter

Overview:
- Central scheduler for the board's service blocks (stopwatch, timers, etc.).
- Each service is requested by its SPDT switch and grants exactly one service at a time, round-robin among pending requests.
- Routes the shared push button and 7-segment bus to and from the granted service, and retires the grant on that service's finish pulse or when its switch is lowered.
- Sits between top-level board I/O and the Service_N instances.

Parameters:
- N_SVC, 4, number of services arbitrated (2..8).
- ID_W, 2, width of active_id; must satisfy 2^ID_W >= N_SVC.
- TIMEOUT_CYCLES, 32'd1_000_000_000, watchdog limit; used only with SVC_WATCHDOG_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- resetn  in  1  synchronous, active-high reset (1 = reset), sampled on clk.
- spdt  in  N_SVC  request switches; bit i high = service i requested.
- push_m  in  1  shared push button, level, already debounced.
- finish  in  N_SVC  one-cycle done pulses from the services.
- seg_in  in  16*N_SVC  service segment buses; service i occupies bits [16*i+15:16*i].
- led_in  in  N_SVC  service LED outputs.
- svc_en  out  N_SVC  one-hot enable to the granted service; all zero when none.
- push_out  out  N_SVC  one-cycle push pulse, sent to the granted service only.
- segments  out  16  muxed display bus.
- led  out  1  LED of the granted service.
- active_id  out  ID_W  index of the granted service.
- busy  out  1  high while a grant is held.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_id = N_SVC-1; push edge register = 0.
- IDLE:
  - Request vector req = spdt.
  - If req != 0, pick the first set bit searching from last_id+1 upward with wrap (round-robin).
  - Register the pick into active_id, set svc_en one-hot, set busy, go to GRANT. Grant is visible 1 cycle after the request is sampled.
- GRANT:
  - segments = seg_in slice[active_id]; led = led_in[active_id].
  - Rising edge of push_m (registered previous value) produces push_out[active_id] = 1 for exactly one cycle. Holding push_m produces one pulse only.
  - Exit on finish[active_id] == 1 or spdt[active_id] == 0: go to RELEASE and set last_id = active_id.
  - finish or spdt changes on non-granted bits are ignored; other raised switches stay pending.
- RELEASE (exactly 1 cycle):
  - svc_en = 0, busy = 0, segments = 16'h0000, led = 0, push_out = 0. active_id holds its old value.
  - Next state is IDLE. This gives the services one clean disable cycle before any re-grant.
- Outside GRANT: segments = 0, led = 0, push_out = 0.
- Boundary conditions:
  - finish pulse and spdt fall in the same cycle: treated as one exit.
  - push edge in the same cycle as the exit: the pulse is suppressed.
  - Single requester re-raised after release: granted again (round-robin wraps to itself).
  - A finish pulse arriving in IDLE or RELEASE is ignored.
  - resetn high in any state: next cycle all outputs return to reset values, regardless of spdt/finish.

Optional Feature:
- Macro SVC_WATCHDOG_EN.
- Defined:
  - A 32-bit counter clears on grant and increments each GRANT cycle.
  - On reaching TIMEOUT_CYCLES-1 without an exit, force RELEASE and pulse an extra output port wd_trip (1 bit, reset 0) for one cycle.
  - last_id updates as for a normal exit.
- Not defined: no counter and no wd_trip port; a grant is held indefinitely.

Test Plan:
- Reset with spdt=4'b0101, finish=0 -> svc_en=0, busy=0, segments=0; one cycle after resetn=0: svc_en=4'b0001, active_id=0.
- Service 0 granted, seg_in slice0=16'h1234, push_m held high 5 cycles -> segments=16'h1234; push_out=4'b0001 for exactly 1 cycle.
- finish[0] pulse with spdt=4'b0101 -> 1 RELEASE cycle (svc_en=0, segments=0), then svc_en=4'b0100, active_id=2.
- Service 2 granted, spdt[2] dropped to 0, spdt=4'b0011 -> release, then grant service 0 (wrap from last_id=2), not service 1.
- Granted service 1, finish[3] pulse and spdt[3] toggled -> no change to svc_en=4'b0010; resetn pulsed high mid-grant -> all outputs 0 the next cycle.
- With SVC_WATCHDOG_EN and TIMEOUT_CYCLES=10, grant held with no finish -> wd_trip=1 and svc_en=0 exactly 10 cycles after grant; without the macro, svc_en is still held after 100 cycles.
